// File: rtl/avr_io_uart.sv
// avr_io_uart: memory-mapped 8N1 UART for the AVR I/O space.
// Registers at BASE_ADDR+0 (UDR), +1 (USR), +2 (UBRR). Bit period is UBRR+1 clocks.
//
// Bus semantics: io_read/io_write are single-cycle strobes qualified by io_sel.
// A write or read takes effect on the rising edge that ends the cycle.
// io_out is purely combinational and has no side effects unless io_read is high.
module avr_io_uart #(
    parameter logic [5:0] BASE_ADDR = 6'h0C
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] io_addr,
    input  logic       io_read,
    input  logic       io_write,
    input  logic [7:0] io_in,
    output logic [7:0] io_out,
    output logic       io_sel,
    output logic       txd,
    input  logic       rxd
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    logic [5:0] offset;
    logic       udr_wr, usr_wr, ubrr_wr, udr_rd;

    logic [7:0] ubrr;
    logic [8:0] period;
    logic [8:0] rx_half;

    // Transmit side
    uart_state_t tx_state, tx_next;
    logic [7:0]  tx_hold, tx_shift;
    logic [8:0]  tx_cnt;
    logic [2:0]  tx_bit;
    logic        udre, txc;
    logic        tx_tick, tx_load, tx_done;

    // Receive side
    uart_state_t rx_state, rx_next;
    logic        rx_s1, rx_s2, rx_prev;
    logic [7:0]  rx_shift, rx_buf;
    logic [8:0]  rx_cnt;
    logic [2:0]  rx_bit;
    logic        rxc, fe, dor;
    logic        rx_tick, rx_fall, rx_go_start, rx_go_data, rx_sample, rx_done;

    // Offset arithmetic wraps in 6 bits, so the window is correct for any BASE_ADDR.
    assign offset  = io_addr - BASE_ADDR;
    assign io_sel  = (offset < 6'd3);
    assign udr_wr  = io_write && io_sel && (offset == 6'd0);
    assign usr_wr  = io_write && io_sel && (offset == 6'd1);
    assign ubrr_wr = io_write && io_sel && (offset == 6'd2);
    assign udr_rd  = io_read  && io_sel && (offset == 6'd0);

    assign period  = {1'b0, ubrr};
    assign rx_half = ({1'b0, ubrr} + 9'd1) >> 1;
    assign tx_tick = (tx_cnt == 9'd0);
    assign rx_tick = (rx_cnt == 9'd0);
    assign rx_fall = rx_prev && !rx_s2;

    // Read mux: selected register or zero.
    always_comb begin
        io_out = 8'h00;
        if (io_sel) begin
            case (offset)
                6'd0:    io_out = rx_buf;
                6'd1:    io_out = {rxc, txc, udre, fe, dor, 3'b000};
                6'd2:    io_out = ubrr;
                default: io_out = 8'h00;
            endcase
        end
    end

    // Baud divisor register; running bits pick it up at their next reload.
    always_ff @(posedge clk) begin
        if (rst) ubrr <= 8'h00;
        else if (ubrr_wr) ubrr <= io_in;
    end

    // TX next-state logic; a pending holding byte chains straight into START.
    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        tx_done = 1'b0;
        case (tx_state)
            S_IDLE:  if (!udre) begin tx_next = S_START; tx_load = 1'b1; end
            S_START: if (tx_tick) tx_next = S_DATA;
            S_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = S_STOP;
            S_STOP: begin
                if (tx_tick) begin
                    if (!udre) begin tx_next = S_START; tx_load = 1'b1; end
                    else begin tx_next = S_IDLE; tx_done = 1'b1; end
                end
            end
            default: tx_next = S_IDLE;
        endcase
    end

    // TX state register.
    always_ff @(posedge clk) begin
        if (rst) tx_state <= S_IDLE;
        else tx_state <= tx_next;
    end

    // TX datapath: holding register, shifter, bit timer and line driver.
    always_ff @(posedge clk) begin
        if (rst) begin
            udre     <= 1'b1;
            tx_hold  <= 8'h00;
            tx_shift <= 8'h00;
            tx_cnt   <= 9'd0;
            tx_bit   <= 3'd0;
            txd      <= 1'b1;
        end else begin
            // A write is accepted only while the holding register is empty.
            if (udr_wr && udre) begin
                tx_hold <= io_in;
                udre    <= 1'b0;
            end else if (tx_load) begin
                udre <= 1'b1;
            end
            if (tx_load) begin
                tx_shift <= tx_hold;
                txd      <= 1'b0;
                tx_cnt   <= period;
                tx_bit   <= 3'd0;
            end else if (tx_state != S_IDLE) begin
                if (tx_tick) begin
                    tx_cnt <= period;
                    case (tx_state)
                        S_START: begin
                            txd      <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end
                        S_DATA: begin
                            if (tx_bit == 3'd7) begin
                                txd <= 1'b1;
                            end else begin
                                txd      <= tx_shift[0];
                                tx_shift <= tx_shift >> 1;
                                tx_bit   <= tx_bit + 3'd1;
                            end
                        end
                        default: txd <= 1'b1;
                    endcase
                end else begin
                    tx_cnt <= tx_cnt - 9'd1;
                end
            end
        end
    end

    // TXC: set when the line goes idle, cleared by writing 1 to USR bit 6.
    always_ff @(posedge clk) begin
        if (rst) txc <= 1'b0;
        else if (tx_done) txc <= 1'b1;
        else if (usr_wr && io_in[6]) txc <= 1'b0;
    end

    // rxd synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // RX next-state logic. Edge detection costs one cycle, so the start
    // countdown is one shorter; with a zero half-period the detecting
    // sample is itself the start-bit sample and START is skipped.
    always_comb begin
        rx_next     = rx_state;
        rx_go_start = 1'b0;
        rx_go_data  = 1'b0;
        rx_sample   = 1'b0;
        rx_done     = 1'b0;
        case (rx_state)
            S_IDLE: begin
                if (rx_fall) begin
                    if (rx_half == 9'd0) begin rx_next = S_DATA; rx_go_data = 1'b1; end
                    else begin rx_next = S_START; rx_go_start = 1'b1; end
                end
            end
            S_START: begin
                if (rx_tick) begin
                    if (rx_s2) rx_next = S_IDLE;
                    else begin rx_next = S_DATA; rx_go_data = 1'b1; end
                end
            end
            S_DATA: begin
                if (rx_tick) begin
                    rx_sample = 1'b1;
                    if (rx_bit == 3'd7) rx_next = S_STOP;
                end
            end
            S_STOP: if (rx_tick) begin rx_next = S_IDLE; rx_done = 1'b1; end
            default: rx_next = S_IDLE;
        endcase
    end

    // RX state register.
    always_ff @(posedge clk) begin
        if (rst) rx_state <= S_IDLE;
        else rx_state <= rx_next;
    end

    // RX datapath: sample timer and LSB-first shifter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt   <= 9'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'h00;
        end else begin
            if (rx_go_start) begin
                rx_cnt <= rx_half - 9'd1;
            end else if (rx_go_data) begin
                rx_cnt <= period;
                rx_bit <= 3'd0;
            end else if (rx_state != S_IDLE) begin
                if (rx_tick) rx_cnt <= period;
                else rx_cnt <= rx_cnt - 9'd1;
            end
            if (rx_sample) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
        end
    end

    // RX buffer and flags; a read coinciding with completion hands over the
    // new byte without flagging an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_buf <= 8'h00;
            rxc    <= 1'b0;
            fe     <= 1'b0;
            dor    <= 1'b0;
        end else if (rx_done) begin
            rx_buf <= rx_shift;
            rxc    <= 1'b1;
            fe     <= !rx_s2;
            dor    <= rxc && !udr_rd;
        end else if (udr_rd) begin
            rxc <= 1'b0;
            dor <= 1'b0;
        end
    end

endmodule

// File: doc/avr_io_uart.md
AVR_IO_UART -- requirements
Module: avr_io_uart

Interface
REQ-001 Parameter BASE_ADDR, default 6'h0C, first of three consecutive I/O addresses owned by the block.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 io_addr  input  6  I/O address driven by the CPU execute stage.
REQ-005 io_read  input  1  CPU reads io_addr this cycle.
REQ-006 io_write  input  1  CPU writes io_addr this cycle.
REQ-007 io_in  input  8  write data from CPU (CPU io_out).
REQ-008 io_out  output  8  read data to CPU (CPU io_in); combinational.
REQ-009 io_sel  output  1  combinational; 1 when io_addr is in BASE_ADDR..BASE_ADDR+2.
REQ-010 txd  output  1  serial transmit line, idle high.
REQ-011 rxd  input  1  serial receive line, asynchronous, idle high.

Function
REQ-012 Register map: BASE+0 UDR (write = TX data, read = RX data); BASE+1 USR (status); BASE+2 UBRR (baud divisor, R/W).
REQ-013 USR bits: 7 RXC, 6 TXC, 5 UDRE, 4 FE, 3 DOR, 2..0 read 0.
REQ-014 io_out = selected register when io_sel, else 8'h00; no dependence on io_read.
REQ-015 Frame 8N1, LSB first: start 0, 8 data, stop 1; bit period = UBRR+1 clk cycles.
REQ-016 TX path: one holding register plus shift register; UDRE=1 means holding register empty.
REQ-017 UDR write with UDRE=1 loads holding register, clears UDRE; UDR write with UDRE=0 is ignored.
REQ-018 TX FSM states IDLE, START, DATA, STOP; IDLE with UDRE=0 -> START next cycle, holding moved to shifter, UDRE set same edge.
REQ-019 txd drops to 0 on the edge entering START; each state/bit lasts exactly UBRR+1 cycles.
REQ-020 End of STOP: if UDRE=0 go directly to START (back-to-back, no idle gap); else IDLE and set TXC.
REQ-021 TXC cleared by writing USR with bit6=1; other USR bits not writable.
REQ-022 rxd double-flop synchronised before use (2-cycle latency, included in all RX timing).
REQ-023 RX FSM states IDLE, START, DATA, STOP; synchronised falling edge in IDLE -> START.
REQ-024 START waits floor((UBRR+1)/2) cycles, samples; 1 = false start -> IDLE, no flags.
REQ-025 DATA samples every UBRR+1 cycles from the start midpoint, 8 bits, shifted in LSB first.
REQ-026 STOP sample: byte to RX buffer, RXC=1, FE = (stop sample==0), DOR=1 if RXC already 1 (old data overwritten); return IDLE.
REQ-027 RX buffer read (io_read at BASE+0) clears RXC and DOR on that edge; FE updated only by next frame completion.
REQ-028 Simultaneous RX completion and UDR read: new byte loaded, RXC stays 1, DOR not set.
REQ-029 UBRR write takes effect at next bit-period reload; bit in progress completes with old count.
REQ-030 Counters are 9 bits wide so UBRR=8'hFF gives a 256-cycle period without wrap; UBRR=0 gives 1-cycle bits.

Reset
REQ-031 On rst: txd=1, UDRE=1, RXC=TXC=FE=DOR=0, UBRR=0, RX buffer=0, both FSMs IDLE, sync flops=1.
REQ-032 Reset mid-frame aborts both directions; txd high on the cycle after the reset edge; no flags set.

Verification
REQ-033 Reset, read USR -> io_out=8'h20; io_sel=0 at io_addr=BASE+3, io_out=0.
REQ-034 UBRR=3, write UDR=8'h55 -> txd 0,1,0,1,0,1,0,1,0,1 each 4 cycles (40 total), then TXC=1, USR=8'h60.
REQ-035 UBRR=3, write 8'hA5 then 8'h3C while first frame in START -> second write accepted, frames contiguous, 80 cycles; third write while UDRE=0 dropped.
REQ-036 UBRR=7, drive rxd frame 8'hC3 -> RXC=1, UDR reads 8'hC3, RXC clears after read; stop bit driven 0 -> FE=1.
REQ-037 Two RX frames without reading -> DOR=1, UDR=second byte; 2-cycle rxd low glitch -> no RXC.
REQ-038 Assert rst during TX DATA bit 4 -> txd=1 next cycle, USR=8'h20, new write transmits full frame.
